// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
// Holds the last good byte, status flags and a level irq for the CPU.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  input  logic       rd_ack,
  output logic [7:0] shift_read,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_sync;
  logic            r_line;
  logic            r_line_d;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_rx_ready;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_fall;
  logic            w_start_mid;
  logic            w_cnt_last;
  logic            w_shift;
  logic            w_stop_ok;
  logic            w_stop_bad;

  // Two-flop synchroniser plus one delay for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 1'b1;
      r_line   <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync   <= uart_in;
      r_line   <= r_sync;
      r_line_d <= r_line;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_start_mid) w_next = r_line ? S_IDLE : S_DATA;
      S_DATA:  if (w_shift && r_idx == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_cnt_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM decode of sample points and stop-bit outcome
  always_comb begin
    w_fall      = r_line_d & ~r_line;
    w_start_mid = (r_state == S_START) && (r_cnt == HALF);
    w_cnt_last  = (r_cnt == LAST);
    w_shift     = (r_state == S_DATA) && w_cnt_last;
    w_stop_ok   = (r_state == S_STOP) && w_cnt_last && r_line;
    w_stop_bad  = (r_state == S_STOP) && w_cnt_last && !r_line;
  end

  // Bit timing, shift register and CPU-visible flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_rx_ready  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_start_mid || w_cnt_last)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_start_mid)  r_idx <= 3'd0;
      else if (w_shift) r_idx <= r_idx + 3'd1;

      if (w_shift) r_shift <= {r_line, r_shift[7:1]};

      // ack clears first; a stop-bit completion in the same cycle wins
      if (rd_ack) begin
        r_rx_ready  <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (w_stop_ok) begin
        r_data      <= r_shift;
        r_rx_ready  <= 1'b1;
        r_frame_err <= 1'b0;
        if (r_rx_ready && !rd_ack) r_overrun <= 1'b1;
      end
      if (w_stop_bad) r_frame_err <= 1'b1;
    end
  end

  assign shift_read = r_shift;
  assign rx_data    = r_data;
  assign rx_ready   = r_rx_ready;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign irq        = r_rx_ready | r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, expected results queued per frame.
// A negedge monitor compares whenever the receiver delivers something.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       uart_in;
  logic       rd_ack;
  logic [7:0] shift_read;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       irq;

  typedef struct packed {
    logic [7:0] sh;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;
    logic       irq;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp;
  int   n_err;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_in   (uart_in),
    .rd_ack    (rd_ack),
    .shift_read(shift_read),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] sh, input logic [7:0] d,
                      input logic r, input logic f, input logic o);
    obs_t e;
    e.sh   = sh;
    e.data = d;
    e.rdy  = r;
    e.ferr = f;
    e.ovr  = o;
    e.irq  = r | f;
    exp_q.push_back(e);
  endtask

  // send one 8N1 frame; optionally pulse rd_ack on the stop-sample edge
  task automatic send(input logic [7:0] b, input logic stop,
                      input logic ack);
    uart_in = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(16);
    end
    uart_in = stop;
    if (ack) begin
      tick(10);
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      tick(5);
    end else begin
      tick(16);
    end
    uart_in = 1'b1;
    tick(4);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    tick(1);
  endtask

  // monitor: a delivery is a new rx_data or a rising error flag
  logic [7:0] p_data;
  logic       p_ferr;
  logic       p_ovr;
  initial begin
    p_data = 8'h00;
    p_ferr = 1'b0;
    p_ovr  = 1'b0;
  end

  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (!rst) begin
      if (rx_data !== p_data || (frame_err && !p_ferr) ||
          (overrun && !p_ovr)) begin
        a = {shift_read, rx_data, rx_ready, frame_err, overrun, irq};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_delivery: got %0h required none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL delivery: got %0h required %0h", a, e);
          end
        end
      end
    end
    p_data = rx_data;
    p_ferr = frame_err;
    p_ovr  = overrun;
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    uart_in = 1'b1;
    rd_ack  = 1'b0;
    tick(4);
    chk("rst_shift", 32'(shift_read), 32'h00);
    chk("rst_data",  32'(rx_data),    32'h00);
    chk("rst_ready", 32'(rx_ready),   32'h0);
    chk("rst_ferr",  32'(frame_err),  32'h0);
    chk("rst_ovr",   32'(overrun),    32'h0);
    chk("rst_irq",   32'(irq),        32'h0);
    rst = 1'b0;
    tick(4);

    push(8'h55, 8'h55, 1'b1, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    ack_pulse();
    chk("ack_ready", 32'(rx_ready), 32'h0);
    chk("ack_irq",   32'(irq),      32'h0);

    uart_in = 1'b0;
    tick(4);
    uart_in = 1'b1;
    tick(30);
    chk("glitch_flags", 32'({rx_ready, frame_err, overrun, irq}), 32'h0);
    chk("glitch_data",  32'(rx_data), 32'h55);

    push(8'hA3, 8'hA3, 1'b1, 1'b0, 1'b0);
    send(8'hA3, 1'b1, 1'b0);
    ack_pulse();

    push(8'hA5, 8'hA3, 1'b0, 1'b1, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    tick(20);
    chk("ferr_irq", 32'(irq), 32'h1);
    push(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    ack_pulse();

    push(8'h12, 8'h12, 1'b1, 1'b0, 1'b0);
    send(8'h12, 1'b1, 1'b0);
    push(8'h34, 8'h34, 1'b1, 1'b0, 1'b1);
    send(8'h34, 1'b1, 1'b0);
    ack_pulse();
    chk("ovr_clr",   32'(overrun),  32'h0);
    chk("ovr_ready", 32'(rx_ready), 32'h0);

    push(8'h56, 8'h56, 1'b1, 1'b0, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    push(8'h78, 8'h78, 1'b1, 1'b0, 1'b0);
    send(8'h78, 1'b1, 1'b1);
    chk("coinc_ready", 32'(rx_ready), 32'h1);
    chk("coinc_ovr",   32'(overrun),  32'h0);
    ack_pulse();

    uart_in = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      uart_in = 1'b1;
      tick(16);
    end
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_out",
        32'({shift_read, rx_data, rx_ready, frame_err, overrun, irq}),
        32'h0);
    tick(20);
    chk("mid_rst_quiet", 32'({rx_ready, frame_err, irq}), 32'h0);

    push(8'hC3, 8'hC3, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    tick(10);

    chk("undelivered", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
